// File: rtl/vga_output_stage.sv
// ---------------------------------------------------------------------------
// vga_output_stage
//
// This is the last stage between the raster scanner and the VGA pins. It
// delays the scan timing (blanking, h/v sync, pixel coordinate LSBs) by the
// renderer's pixel-pipeline latency so that timing lines up with the colour
// arriving on r/g/b_in. It ordered-dithers each channel down to 2 bits,
// blanks outside the active area, and registers everything into the pins.
// It also keeps the frame counter that drives temporal dithering.
//
// Parameters
//   PIXEL_LATENCY   enabled cycles from scan outputs to valid r/g/b_in (1..8)
//   COLOR_BITS      bits per channel on r/g/b_in (4..8)
//   SYNC_NEG        1: sync pins active-low, 0: active-high
//   FRAME_BITS      width of frame_counter
//   DITHER_TEMPORAL 1: invert the Bayer threshold index on odd frames
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   enable               pixel-clock enable shared with the scanner
//   h_active, v_active   active-area flags from the scanner (undelayed)
//   hsync, vsync         active-high syncs from the scanner (undelayed)
//   new_frame            one-clock frame-start pulse (not gated by enable)
//   x_lsb, y_lsb         pixel coordinate LSBs (undelayed)
//   r_in, g_in, b_in     colour for the pixel issued PIXEL_LATENCY enables ago
//   vga_r, vga_g, vga_b  registered 2-bit pin colour
//   vga_hsync, vga_vsync registered sync pins, polarity set by SYNC_NEG
//   frame_counter        frames since reset, wraps at 2^FRAME_BITS
// ---------------------------------------------------------------------------
module vga_output_stage #(
  parameter int PIXEL_LATENCY   = 2,
  parameter int COLOR_BITS      = 4,
  parameter int SYNC_NEG        = 1,
  parameter int FRAME_BITS      = 8,
  parameter int DITHER_TEMPORAL = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  h_active,
  input  logic                  v_active,
  input  logic                  hsync,
  input  logic                  vsync,
  input  logic                  new_frame,
  input  logic                  x_lsb,
  input  logic                  y_lsb,
  input  logic [COLOR_BITS-1:0] r_in,
  input  logic [COLOR_BITS-1:0] g_in,
  input  logic [COLOR_BITS-1:0] b_in,
  output logic [1:0]            vga_r,
  output logic [1:0]            vga_g,
  output logic [1:0]            vga_b,
  output logic                  vga_hsync,
  output logic                  vga_vsync,
  output logic [FRAME_BITS-1:0] frame_counter
);

  localparam int unsigned PL       = PIXEL_LATENCY;
  localparam int unsigned SHIFT    = COLOR_BITS - 4;
  localparam logic        SYNC_LVL = (SYNC_NEG != 0);
  localparam logic        TEMPORAL = (DITHER_TEMPORAL != 0);

  // One delay-line entry: everything the scanner says about one pixel.
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic xl;
    logic yl;
  } scan_t;

  scan_t                 r_dly [PL];
  scan_t                 w_scan;
  scan_t                 w_tail;

  logic [1:0]            r_vga_r;
  logic [1:0]            r_vga_g;
  logic [1:0]            r_vga_b;
  logic                  r_vga_hs;
  logic                  r_vga_vs;
  logic [FRAME_BITS-1:0] r_frame_cnt;

  logic [1:0]            w_bayer;
  logic [1:0]            w_idx;
  logic [COLOR_BITS:0]   w_thr;
  logic [1:0]            w_dith_r;
  logic [1:0]            w_dith_g;
  logic [1:0]            w_dith_b;

  // 2x2 Bayer matrix indexed by {y,x}.
  function automatic logic [1:0] bayer2(input logic xl, input logic yl);
    case ({yl, xl})
      2'b00:   bayer2 = 2'd0;
      2'b01:   bayer2 = 2'd2;
      2'b10:   bayer2 = 2'd3;
      default: bayer2 = 2'd1;
    endcase
  endfunction

  // Add the threshold with one extra bit of headroom; a carry into that bit
  // saturates to full scale rather than wrapping back to dark.
  function automatic logic [1:0] dither_ch(input logic [COLOR_BITS-1:0] c,
                                           input logic [COLOR_BITS:0]   thr);
    logic [COLOR_BITS:0] sum;
    sum = {1'b0, c} + thr;
    if (sum[COLOR_BITS]) dither_ch = 2'b11;
    else                 dither_ch = sum[COLOR_BITS-1 -: 2];
  endfunction

  // ------------------------------------------------------------------------
  // Scan-side timing delay line
  // ------------------------------------------------------------------------
  always_comb begin
    w_scan        = '0;
    w_scan.active = h_active & v_active;
    w_scan.hs     = hsync;
    w_scan.vs     = vsync;
    w_scan.xl     = x_lsb;
    w_scan.yl     = y_lsb;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < PL; i++) begin
        r_dly[i] <= '0;
      end
    end else if (enable) begin
      r_dly[0] <= w_scan;
      for (int unsigned i = 1; i < PL; i++) begin
        r_dly[i] <= r_dly[i-1];
      end
    end
  end

  assign w_tail = r_dly[PL-1];

  // ------------------------------------------------------------------------
  // Ordered dither
  // ------------------------------------------------------------------------
  always_comb begin
    w_bayer = bayer2(w_tail.xl, w_tail.yl);
    // 3 - v on two bits is a bitwise invert.
    if (TEMPORAL && r_frame_cnt[0]) w_idx = ~w_bayer;
    else                            w_idx = w_bayer;
    w_thr    = {{(COLOR_BITS-1){1'b0}}, w_idx} << SHIFT;
    w_dith_r = dither_ch(r_in, w_thr);
    w_dith_g = dither_ch(g_in, w_thr);
    w_dith_b = dither_ch(b_in, w_thr);
  end

  // ------------------------------------------------------------------------
  // Pin registers: one more enabled cycle after the delay-line tail, so
  // sync, blank and colour all reach the pins PIXEL_LATENCY+1 enables after
  // the scanner issued them.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vga_r  <= '0;
      r_vga_g  <= '0;
      r_vga_b  <= '0;
      r_vga_hs <= SYNC_LVL;
      r_vga_vs <= SYNC_LVL;
    end else if (enable) begin
      if (w_tail.active) begin
        r_vga_r <= w_dith_r;
        r_vga_g <= w_dith_g;
        r_vga_b <= w_dith_b;
      end else begin
        r_vga_r <= '0;
        r_vga_g <= '0;
        r_vga_b <= '0;
      end
      r_vga_hs <= w_tail.hs ^ SYNC_LVL;
      r_vga_vs <= w_tail.vs ^ SYNC_LVL;
    end
  end

  // ------------------------------------------------------------------------
  // Frame counter: counts every new_frame pulse whether or not the pixel
  // enable is high.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_cnt <= '0;
    end else if (new_frame) begin
      r_frame_cnt <= r_frame_cnt + {{(FRAME_BITS-1){1'b0}}, 1'b1};
    end
  end

  assign vga_r         = r_vga_r;
  assign vga_g         = r_vga_g;
  assign vga_b         = r_vga_b;
  assign vga_hsync     = r_vga_hs;
  assign vga_vsync     = r_vga_vs;
  assign frame_counter = r_frame_cnt;

endmodule
